ctx_switch_ctrl: RTL and testbench

Sequences context save and restore between one core's register file and the work queue. On a save it reads all 16 general registers through the register file's four read ports over four beats, packs them into one context word and pushes it to the work queue. On a restore it pops a context word and writes it back with the register file's bulk-write path. While it runs it stalls the issue pipeline, so it has exclusive use of the read ports and the bulk-write path.

---
 rtl/ctx_switch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ctx_switch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_switch_ctrl.sv
// ---------------------------------------------------------------------------
// ctx_switch_ctrl: saves/restores one core context between register file and
// work queue; predicate save/restore is enabled by defining CTX_PRED_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctx_switch_ctrl #(
  parameter int NREGS  = 16,
  parameter int RW     = 16,
  parameter int RPORTS = 4,
`ifdef CTX_PRED_EN
  localparam int CTX_W = NREGS * RW + 4
`else
  localparam int CTX_W = NREGS * RW
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   save_req,
  input  logic                   restore_req,
  output logic                   busy,
  output logic                   pipe_stall,
  output logic                   done,
  output logic [4*RPORTS-1:0]    rf_raddr,
  input  logic [RW*RPORTS-1:0]   rf_rdata,
  output logic                   rf_bulk_wen,
  output logic [NREGS*RW-1:0]    rf_bulk_wdata,
  input  logic [3:0]             rf_pred_all,
  output logic                   rf_pred_wen,
  output logic [3:0]             rf_pred_wdata,
  output logic                   wq_push_valid,
  input  logic                   wq_push_ready,
  output logic [CTX_W-1:0]       wq_push_data,
  input  logic                   wq_pop_valid,
  output logic                   wq_pop_ready,
  input  logic [CTX_W-1:0]       wq_pop_data
);

  localparam int              NBEATS    = NREGS / RPORTS;
  localparam int              BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(NBEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SAVE_RD   = 3'd1,
    S_SAVE_CAP  = 3'd2,
    S_SAVE_PUSH = 3'd3,
    S_RST_WAIT  = 3'd4,
    S_RST_WR    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t               r_state;
  logic [BW-1:0]        r_beat;
  logic [CTX_W-1:0]     r_buf;
  logic [4*RPORTS-1:0]  r_raddr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_push_valid;
  logic                 r_pop_ready;
  logic                 r_bulk_wen;
  logic                 r_pred_wen;

  logic [BW-1:0]        w_prev_beat;
  logic [CTX_W-1:0]     w_cap_last;

  function automatic logic [4*RPORTS-1:0] f_raddr(input logic [BW-1:0] beat);
    logic [4*RPORTS-1:0] v;
    v = '0;
    for (int p = 0; p < RPORTS; p++) begin
      v[4*p +: 4] = 4'(RPORTS * int'(beat) + p);
    end
    return v;
  endfunction

  function automatic logic [CTX_W-1:0] f_capture(input logic [CTX_W-1:0]     buf_in,
                                                 input logic [BW-1:0]        beat,
                                                 input logic [RW*RPORTS-1:0] data);
    logic [CTX_W-1:0] v;
    v = buf_in;
    for (int p = 0; p < RPORTS; p++) begin
      v[RW*(RPORTS*int'(beat) + p) +: RW] = data[RW*p +: RW];
    end
    return v;
  endfunction

  // Read data lags the address by one cycle, so each beat stores the previous one.
  assign w_prev_beat = r_beat - 1'b1;

  always_comb begin
    w_cap_last = f_capture(r_buf, LAST_BEAT, rf_rdata);
`ifdef CTX_PRED_EN
    w_cap_last[CTX_W-1 -: 4] = rf_pred_all;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_buf        <= '0;
      r_raddr      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_push_valid <= 1'b0;
      r_pop_ready  <= 1'b0;
      r_bulk_wen   <= 1'b0;
      r_pred_wen   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_bulk_wen <= 1'b0;
      r_pred_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (save_req) begin
            r_state <= S_SAVE_RD;
            r_beat  <= '0;
            r_busy  <= 1'b1;
            r_raddr <= f_raddr('0);
          end else if (restore_req) begin
            r_state     <= S_RST_WAIT;
            r_busy      <= 1'b1;
            r_pop_ready <= 1'b1;
          end
        end
        S_SAVE_RD: begin
          if (r_beat != '0) begin
            r_buf <= f_capture(r_buf, w_prev_beat, rf_rdata);
          end
          if (r_beat == LAST_BEAT) begin
            r_state <= S_SAVE_CAP;
            r_raddr <= '0;
          end else begin
            r_beat  <= r_beat + 1'b1;
            r_raddr <= f_raddr(r_beat + 1'b1);
          end
        end
        S_SAVE_CAP: begin
          r_buf        <= w_cap_last;
          r_beat       <= '0;
          r_push_valid <= 1'b1;
          r_state      <= S_SAVE_PUSH;
        end
        S_SAVE_PUSH: begin
          if (wq_push_ready) begin
            r_push_valid <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_RST_WAIT: begin
          if (wq_pop_valid) begin
            r_buf       <= wq_pop_data;
            r_pop_ready <= 1'b0;
            r_bulk_wen  <= 1'b1;
            r_pred_wen  <= 1'b1;
            r_state     <= S_RST_WR;
          end
        end
        S_RST_WR: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_push_valid <= 1'b0;
          r_pop_ready  <= 1'b0;
          r_raddr      <= '0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign pipe_stall    = r_busy;
  assign done          = r_done;
  assign rf_raddr      = r_raddr;
  assign rf_bulk_wen   = r_bulk_wen;
  assign rf_bulk_wdata = r_buf[NREGS*RW-1:0];
  assign wq_push_valid = r_push_valid;
  assign wq_push_data  = r_buf;
  assign wq_pop_ready  = r_pop_ready;

`ifdef CTX_PRED_EN
  assign rf_pred_wen   = r_pred_wen;
  assign rf_pred_wdata = r_buf[CTX_W-1 -: 4];
`else
  logic w_unused_pred;
  assign w_unused_pred = ^{rf_pred_all, r_pred_wen};
  assign rf_pred_wen   = 1'b0;
  assign rf_pred_wdata = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctx_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ctx_switch_ctrl: scoreboard bench for ctx_switch_ctrl (honours CTX_PRED_EN). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ctx_switch_ctrl;

  localparam int NREGS  = 16;
  localparam int RW     = 16;
  localparam int RPORTS = 4;
`ifdef CTX_PRED_EN
  localparam int CTX_W = NREGS * RW + 4;
`else
  localparam int CTX_W = NREGS * RW;
`endif

  typedef struct {
    logic [CTX_W-1:0] data;
    int               cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  save_req = 1'b0;
  logic                  restore_req = 1'b0;
  logic                  busy, pipe_stall, done;
  logic [4*RPORTS-1:0]   rf_raddr;
  logic [RW*RPORTS-1:0]  rf_rdata = '0;
  logic                  rf_bulk_wen;
  logic [NREGS*RW-1:0]   rf_bulk_wdata;
  logic [3:0]            pred = 4'd0;
  logic                  rf_pred_wen;
  logic [3:0]            rf_pred_wdata;
  logic                  wq_push_valid;
  logic                  wq_push_ready = 1'b0;
  logic [CTX_W-1:0]      wq_push_data;
  logic                  wq_pop_valid = 1'b0;
  logic                  wq_pop_ready;
  logic [CTX_W-1:0]      wq_pop_data = '0;

  logic [RW-1:0]         regs [NREGS];
  int                    cyc = 0;
  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    push_d = 0;
  int                    pop_d = 0;
  int                    busy_lo = 1, busy_hi = 0;
  int                    pv_lo = 1, pv_hi = 0;
  int                    pr_lo = 1, pr_hi = 0;
  exp_t                  q_raddr[$];
  exp_t                  q_push[$];
  exp_t                  q_bulk[$];
  exp_t                  q_done[$];

  ctx_switch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .save_req      (save_req),
    .restore_req   (restore_req),
    .busy          (busy),
    .pipe_stall    (pipe_stall),
    .done          (done),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .rf_bulk_wen   (rf_bulk_wen),
    .rf_bulk_wdata (rf_bulk_wdata),
    .rf_pred_all   (pred),
    .rf_pred_wen   (rf_pred_wen),
    .rf_pred_wdata (rf_pred_wdata),
    .wq_push_valid (wq_push_valid),
    .wq_push_ready (wq_push_ready),
    .wq_push_data  (wq_push_data),
    .wq_pop_valid  (wq_pop_valid),
    .wq_pop_ready  (wq_pop_ready),
    .wq_pop_data   (wq_pop_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: one-cycle read latency on every port.
  always @(posedge clk) begin
    for (int p = 0; p < RPORTS; p++) begin
      rf_rdata[RW*p +: RW] <= regs[rf_raddr[4*p +: 4]];
    end
  end

  // Queue endpoints: ready/valid rise after the configured number of waiting cycles.
  initial begin
    int cnt_push;
    int cnt_pop;
    cnt_push = 0;
    cnt_pop  = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt_push      = (wq_push_valid === 1'b1) ? cnt_push + 1 : 0;
      cnt_pop       = (wq_pop_ready === 1'b1) ? cnt_pop + 1 : 0;
      wq_push_ready = (cnt_push > push_d);
      wq_pop_valid  = (cnt_pop > pop_d);
    end
  end

  task automatic check(input string nm, input logic [CTX_W-1:0] act, input logic [CTX_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic in_win(input int lo, input int hi);
    return (cyc >= lo) && (cyc <= hi);
  endfunction

  function automatic logic [CTX_W-1:0] ctx_word();
    logic [CTX_W-1:0] w;
    w = '0;
    for (int i = 0; i < NREGS; i++) w[RW*i +: RW] = regs[i];
`ifdef CTX_PRED_EN
    w[CTX_W-1 -: 4] = pred;
`endif
    return w;
  endfunction

  function automatic logic [CTX_W-1:0] raddr_exp(input int beat);
    logic [CTX_W-1:0] v;
    v = '0;
    for (int p = 0; p < RPORTS; p++) v[4*p +: 4] = 4'(RPORTS * beat + p);
    return v;
  endfunction

  // Monitor: window checks every cycle, event queues popped when the DUT acts.
  initial begin
    exp_t             e;
    logic             ev;
    logic             prev_stall;
    logic [CTX_W-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      check("busy", busy, in_win(busy_lo, busy_hi));
      check("pipe_stall", pipe_stall, in_win(busy_lo, busy_hi));
      check("push_valid", wq_push_valid, in_win(pv_lo, pv_hi));
      check("pop_ready", wq_pop_ready, in_win(pr_lo, pr_hi));
      if (prev_stall) check("push_hold_data", wq_push_data, prev_data);
      prev_stall = (wq_push_valid === 1'b1) && (wq_push_ready === 1'b0) && (reset === 1'b0);
      prev_data  = wq_push_data;

      ev = (rf_raddr !== '0);
      if (ev) begin
        if (q_raddr.size() == 0) check("raddr_unexpected", rf_raddr, '0);
        else begin
          e = q_raddr.pop_front();
          check("raddr", rf_raddr, e.data);
          check("raddr_cycle", cyc, e.cyc);
        end
      end else if (q_raddr.size() != 0 && q_raddr[0].cyc <= cyc) begin
        e = q_raddr.pop_front();
        check("raddr", rf_raddr, e.data);
      end

      ev = (wq_push_valid === 1'b1) && (wq_push_ready === 1'b1);
      if (ev) begin
        if (q_push.size() == 0) check("push_unexpected", ev, '0);
        else begin
          e = q_push.pop_front();
          check("push_data", wq_push_data, e.data);
          check("push_cycle", cyc, e.cyc);
        end
      end else if (q_push.size() != 0 && q_push[0].cyc <= cyc) begin
        void'(q_push.pop_front());
        check("push_handshake", ev, 1);
      end

      ev = (rf_bulk_wen !== 1'b0);
      if (ev) begin
        if (q_bulk.size() == 0) check("bulk_unexpected", rf_bulk_wen, '0);
        else begin
          e = q_bulk.pop_front();
          check("bulk_data", rf_bulk_wdata, e.data[NREGS*RW-1:0]);
          check("bulk_cycle", cyc, e.cyc);
`ifdef CTX_PRED_EN
          check("pred_wen", rf_pred_wen, 1);
          check("pred_wdata", rf_pred_wdata, e.data[CTX_W-1 -: 4]);
`endif
        end
      end else if (q_bulk.size() != 0 && q_bulk[0].cyc <= cyc) begin
        void'(q_bulk.pop_front());
        check("bulk_wen", rf_bulk_wen, 1);
      end
`ifdef CTX_PRED_EN
      if (!ev) check("pred_wen_idle", rf_pred_wen, '0);
`else
      check("pred_wen_off", rf_pred_wen, '0);
      check("pred_wdata_off", rf_pred_wdata, '0);
`endif

      ev = (done !== 1'b0);
      if (ev) begin
        if (q_done.size() == 0) check("done_unexpected", done, '0);
        else begin
          e = q_done.pop_front();
          check("done_cycle", cyc, e.cyc);
        end
      end else if (q_done.size() != 0 && q_done[0].cyc <= cyc) begin
        void'(q_done.pop_front());
        check("done_pulse", done, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q_done.size() != 0 && k < 400) begin
      step();
      k++;
    end
    if (q_done.size() != 0) begin
      check("done_timeout", q_done.size(), '0);
      q_done.delete();
    end
  endtask

  task automatic start_save(input int d, input bit with_restore, output int t0);
    exp_t x;
    t0          = cyc + 1;
    push_d      = d;
    save_req    = 1'b1;
    restore_req = with_restore;
    for (int b = 0; b < NREGS / RPORTS; b++) begin
      x.data = raddr_exp(b);
      x.cyc  = t0 + b;
      q_raddr.push_back(x);
    end
    x.data = ctx_word();
    x.cyc  = t0 + 5 + d;
    q_push.push_back(x);
    x.data = '0;
    x.cyc  = t0 + 6 + d;
    q_done.push_back(x);
    busy_lo = t0;
    busy_hi = t0 + 6 + d;
    pv_lo   = t0 + 5;
    pv_hi   = t0 + 5 + d;
    step();
    restore_req = 1'b0;
  endtask

  task automatic do_save(input int d, input bit with_restore, input bit hold);
    int t0;
    start_save(d, with_restore, t0);
    if (!hold) save_req = 1'b0;
    wait_done();
    save_req = 1'b0;
  endtask

  task automatic do_restore(input int pd, input logic [CTX_W-1:0] w);
    exp_t x;
    int   t0;
    t0          = cyc + 1;
    pop_d       = pd;
    wq_pop_data = w;
    restore_req = 1'b1;
    x.data = w;
    x.cyc  = t0 + 1 + pd;
    q_bulk.push_back(x);
    x.data = '0;
    x.cyc  = t0 + 2 + pd;
    q_done.push_back(x);
    busy_lo = t0;
    busy_hi = t0 + 2 + pd;
    pr_lo   = t0;
    pr_hi   = t0 + pd;
    step();
    restore_req = 1'b0;
    wait_done();
  endtask

  initial begin
    logic [CTX_W-1:0] w;
    int               t0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    for (int i = 0; i < NREGS; i++) regs[i] = 16'hA000 + RW'(i);
    do_save(0, 1'b0, 1'b0);
    step();
    do_save(5, 1'b0, 1'b0);
    step();

    w = '0;
    for (int i = 0; i < NREGS; i++) w[RW*i +: RW] = 16'h5A00 + RW'(i);
    do_restore(0, w);
    step();

    do_save(0, 1'b1, 1'b1);
    repeat (2) step();

    // Reset while a push is stalled: the context must vanish without a done.
    start_save(1000, 1'b0, t0);
    save_req = 1'b0;
    while (cyc < t0 + 7) step();
    reset = 1'b1;
    q_push.delete();
    q_done.delete();
    busy_hi = cyc;
    pv_hi   = cyc;
    step();
    reset  = 1'b0;
    push_d = 0;
    repeat (3) step();

`ifdef CTX_PRED_EN
    pred = 4'b1010;
    for (int i = 0; i < NREGS; i++) regs[i] = 16'hA000 + RW'(i);
    w = ctx_word();
    do_save(0, 1'b0, 1'b0);
    step();
    pred = 4'b0000;
    do_restore(0, w);
    step();
`endif

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = RW'($urandom);
      pred = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_save($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        for (int k = 0; k < CTX_W; k++) w[k] = 1'($urandom_range(0, 1));
        do_restore($urandom_range(0, 4), w);
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    check("leftover_events", q_raddr.size() + q_push.size() + q_bulk.size() + q_done.size(), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
